bus_xfer_ctrl: RTL
==================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter: NREG, 4, number of bus registers; fixed at 4 in this revision.
REQ-002 Parameter: HOLD, 1, cycles each Rout/Rin strobe pair is held (1..15).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  1  transfer request; qualified by ready.
REQ-006 Port: op  input  1  0=MOVE, 1=SWAP.
REQ-007 Port: src  input  2  source register index.
REQ-008 Port: dst  input  2  destination register index.
REQ-009 Port: ready  output  1  high only in IDLE; request accepted when req&&ready at an edge.
REQ-010 Port: Rout  output  4  one-hot register output-enable strobes (bus driver select).
REQ-011 Port: Rin  output  4  one-hot register load strobes.
REQ-012 Port: done  output  1  one-cycle completion pulse.
REQ-013 Port: err  output  1  one-cycle pulse coincident with done for a rejected request.

Function
REQ-014 FSM states SHALL be IDLE, STEP1, STEP2, STEP3, DONE.
REQ-015 On accept, src/dst/op SHALL be latched; later input changes have no effect until next accept.
REQ-016 MOVE: IDLE->STEP1; Rout[src] and Rin[dst] high for HOLD cycles starting the cycle after accept; then DONE.
REQ-017 SWAP (A=src, B=dst, T=3): STEP1 A->T, STEP2 B->A, STEP3 T->B, each HOLD cycles, back-to-back, then DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, then IDLE.
REQ-019 MOVE latency: accept edge E; strobes cycles E+1..E+HOLD; done cycle E+HOLD+1; ready cycle E+HOLD+2.
REQ-020 At most one Rout bit and at most one Rin bit SHALL be high in any cycle; Rout and Rin never select the same register.
REQ-021 Rejected request (src==dst; or SWAP with src==3 or dst==3) SHALL go IDLE->DONE with no strobes, done=1, err=1.
REQ-022 req while ready=0 SHALL be ignored (not queued).
REQ-023 Internal hold counter SHALL be 4 bits, reload to HOLD-1 at each step entry, step advances when it reaches 0.
REQ-024 Registered outputs: strobes asserted from state flops, glitch-free, no combinational path from req to Rout/Rin.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, Rout=0, Rin=0, done=0, err=0, ready=1 from the following cycle, including mid-STEP.
REQ-026 A request presented with rst=1 SHALL not be accepted.

Configuration
REQ-027 Macro BUS_XFER_CTRL_SWAP_EN defined: SWAP per REQ-017.
REQ-028 Macro undefined: op input ignored, every request executes as MOVE, STEP2/STEP3 logic absent; SWAP-specific T checks of REQ-021 not applied.

Structure
REQ-029 Package bus_xfer_pkg SHALL hold the state encoding, op codes (OP_MOVE, OP_SWAP), NREG and temp index TEMP_REG=3.
REQ-030 Sub-module bus_onehot_dec (2-bit index + enable -> 4-bit one-hot) SHALL be instantiated twice, for Rout and Rin.

Verification
REQ-031 Reset: rst high 1 cycle mid-MOVE -> next cycle Rout=0, Rin=0, ready=1, done=0.
REQ-032 MOVE src=0,dst=1,HOLD=1 -> cycle E+1 Rout=0001, Rin=0010; E+2 done=1, err=0; E+3 ready=1.
REQ-033 MOVE src=1,dst=0,HOLD=3 -> Rout=0010, Rin=0001 for exactly 3 cycles, then done pulse.
REQ-034 SWAP src=0,dst=1,HOLD=1 (SWAP_EN) -> E+1 Rout=0001/Rin=1000; E+2 Rout=0010/Rin=0001; E+3 Rout=1000/Rin=0010; E+4 done=1.
REQ-035 MOVE src=2,dst=2 -> no strobes, E+1 done=1, err=1; SWAP dst=3 -> same.
REQ-036 req held high during busy with changing src/dst -> only first request executes; one-hot invariant (REQ-020) asserted every cycle.

Source files
------------

// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the register-bus transfer controller.
package bus_xfer_pkg;

    localparam int NREG = 4;
    localparam logic [1:0] TEMP_REG = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP1 = 3'd1,
        S_STEP2 = 3'd2,
        S_STEP3 = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef enum logic {
        OP_MOVE = 1'b0,
        OP_SWAP = 1'b1
    } op_e;

endpackage

// File: rtl/bus_onehot_dec.sv
// 2-bit register index plus enable to 4-bit one-hot strobe.
module bus_onehot_dec (
    input  logic [1:0] idx,
    input  logic       en,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = 4'b0000;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-bus transfer sequencer: MOVE, plus SWAP through temp register 3
// when BUS_XFER_CTRL_SWAP_EN is defined.
module bus_xfer_ctrl #(
    parameter int NREG = bus_xfer_pkg::NREG,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            op,
    input  logic [1:0]      src,
    input  logic [1:0]      dst,
    output logic            ready,
    output logic [NREG-1:0] Rout,
    output logic [NREG-1:0] Rin,
    output logic            done,
    output logic            err
);
    import bus_xfer_pkg::*;

    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    state_e     state;
    logic [3:0] cnt;
    logic [1:0] out_idx;
    logic [1:0] in_idx;
    logic       strb_en;
    logic       is_swap;
    logic       bad_req;

`ifdef BUS_XFER_CTRL_SWAP_EN
    logic [1:0] a_q;
    logic [1:0] b_q;
    op_e        op_q;

    assign is_swap = (op_e'(op) == OP_SWAP);
`else
    logic unused_op;

    assign unused_op = op;
    assign is_swap   = 1'b0;
`endif

    // Temp-register conflicts only matter when the swap path exists.
    assign bad_req = (src == dst) || (is_swap && (src == TEMP_REG || dst == TEMP_REG));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            strb_en <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            ready   <= 1'b1;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        ready <= 1'b0;
`ifdef BUS_XFER_CTRL_SWAP_EN
                        a_q  <= src;
                        b_q  <= dst;
                        op_q <= op_e'(op);
`endif
                        if (bad_req) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state   <= S_STEP1;
                            strb_en <= 1'b1;
                            cnt     <= HOLD_M1;
                            out_idx <= src;
                            in_idx  <= is_swap ? TEMP_REG : dst;
                        end
                    end
                end
                S_STEP1: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
`ifdef BUS_XFER_CTRL_SWAP_EN
                    end else if (op_q == OP_SWAP) begin
                        state   <= S_STEP2;
                        cnt     <= HOLD_M1;
                        out_idx <= b_q;
                        in_idx  <= a_q;
`endif
                    end else begin
                        state   <= S_DONE;
                        strb_en <= 1'b0;
                        done    <= 1'b1;
                    end
                end
`ifdef BUS_XFER_CTRL_SWAP_EN
                S_STEP2: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state   <= S_STEP3;
                        cnt     <= HOLD_M1;
                        out_idx <= TEMP_REG;
                        in_idx  <= b_q;
                    end
                end
                S_STEP3: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state   <= S_DONE;
                        strb_en <= 1'b0;
                        done    <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    strb_en <= 1'b0;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

    // Strobes decode only from flops, so req never reaches Rout/Rin combinationally.
    bus_onehot_dec u_rout_dec (
        .idx    (out_idx),
        .en     (strb_en),
        .onehot (Rout)
    );

    bus_onehot_dec u_rin_dec (
        .idx    (in_idx),
        .en     (strb_en),
        .onehot (Rin)
    );

endmodule
